// File: rtl/writeback_stage.sv
`timescale 1ns/1ps
// writeback_stage: final pipeline stage. Owns the single register-file write
// port and merges single-cycle ALU results with load responses. Loads are
// byte/half extracted on entry and buffered in a small in-order queue.
// The queue head has priority only when the queue is full; otherwise the ALU wins.
// Writes to x0 are consumed but never drive rf_we.
// Lane extraction assumes XLEN >= 32.
module writeback_stage #(
    parameter int XLEN     = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [1:0]      ld_offset,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            ld_pending
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(LQ_DEPTH);

    logic [CW-1:0]   count;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [4:0]      lq_rd   [LQ_DEPTH];
    logic [XLEN-1:0] lq_data [LQ_DEPTH];

    logic            full;
    logic            empty;
    logic            enq;
    logic            deq;
    logic            win;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign ld_ready   = !full;
    // No same-cycle dequeue credit: a full queue stalls the ALU as well.
    assign alu_ready  = !full;
    assign ld_pending = !empty;
    assign enq        = ld_valid && ld_ready;

    // Select the addressed lane and sign/zero extend before the load is queued.
    always_comb begin
        ld_byte = 8'd0;
        ld_half = 16'd0;
        ld_ext  = '0;
        case (ld_offset)
            2'd0:    ld_byte = ld_data[7:0];
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            default: ld_byte = ld_data[31:24];
        endcase
        ld_half = ld_offset[1] ? ld_data[31:16] : ld_data[15:0];
        case (ld_size)
            2'd0:    ld_ext = {{(XLEN-8){~ld_unsigned & ld_byte[7]}}, ld_byte};
            2'd1:    ld_ext = {{(XLEN-16){~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_ext = ld_data;
        endcase
    end

    // Pick one writer per cycle: full queue, then ALU, then any queued load.
    always_comb begin
        win      = 1'b0;
        deq      = 1'b0;
        win_rd   = 5'd0;
        win_data = '0;
        if (full) begin
            win      = 1'b1;
            deq      = 1'b1;
            win_rd   = lq_rd[head];
            win_data = lq_data[head];
        end else if (alu_valid) begin
            win      = 1'b1;
            win_rd   = alu_rd;
            win_data = alu_data;
        end else if (!empty) begin
            win      = 1'b1;
            deq      = 1'b1;
            win_rd   = lq_rd[head];
            win_data = lq_data[head];
        end
    end

    // Queue payload storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            lq_rd[tail]   <= ld_rd;
            lq_data[tail] <= ld_ext;
        end
    end

    // Queue pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered write port; address/data hold when nobody wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else begin
            rf_we <= win && (win_rd != 5'd0);
            if (win) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
`timescale 1ns/1ps
// Bench for writeback_stage. ALU results use rd 1..15 and loads rd 16..31 so
// the write monitor can route each write to the right in-order scoreboard.
module tb_writeback_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [1:0]      ld_size;
    logic            ld_unsigned;
    logic [1:0]      ld_offset;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            ld_pending;

    int tests  = 0;
    int errors = 0;

    logic [36:0] alu_exp[$];
    logic [36:0] ld_exp[$];

    writeback_stage #(.XLEN(XLEN), .LQ_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_size(ld_size), .ld_unsigned(ld_unsigned), .ld_offset(ld_offset),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ld_pending(ld_pending)
    );

    always #5 clk = ~clk;

    // Scoreboard: every register-file write must match the oldest expected entry of its stream.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            logic [36:0] e;
            tests++;
            if (rf_waddr >= 5'd16) begin
                if (ld_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load_write addr=%0d data=%h", rf_waddr, rf_wdata);
                end else begin
                    e = ld_exp.pop_front();
                    if ({rf_waddr, rf_wdata} !== e) begin
                        errors++;
                        $display("FAIL load_write got rd=%0d data=%h want rd=%0d data=%h",
                                 rf_waddr, rf_wdata, e[36:32], e[31:0]);
                    end
                end
            end else begin
                if (alu_exp.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_alu_write addr=%0d data=%h", rf_waddr, rf_wdata);
                end else begin
                    e = alu_exp.pop_front();
                    if ({rf_waddr, rf_wdata} !== e) begin
                        errors++;
                        $display("FAIL alu_write got rd=%0d data=%h want rd=%0d data=%h",
                                 rf_waddr, rf_wdata, e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if ({rf_we, rf_waddr, rf_wdata, ld_pending, ld_ready, alu_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL reset_state got we=%b addr=%0d data=%h pend=%b ldr=%b alur=%b want 0/0/0/0/1/1",
                         rf_we, rf_waddr, rf_wdata, ld_pending, ld_ready, alu_ready);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        alu_exp.push_back({5'd5, 32'hDEADBEEF});
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (rf_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_write got we=%b want 1", rf_we);
        end
        step();
        @(negedge clk);
        tests++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_after got we=%b want 0", rf_we);
        end
        step();
    endtask

    task automatic test_extract();
        logic [1:0]  sizes [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        logic [1:0]  offs  [5] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd1};
        logic        uns   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exps  [5] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF, 32'hFFFF80FF, 32'h80FF7F01};
        for (int i = 0; i < 5; i++) begin
            ld_valid    = 1'b1;
            ld_rd       = 5'(16 + i);
            ld_data     = 32'h80FF7F01;
            ld_size     = sizes[i];
            ld_offset   = offs[i];
            ld_unsigned = uns[i];
            ld_exp.push_back({5'(16 + i), exps[i]});
            step();
            ld_valid = 1'b0;
            @(negedge clk);
            tests++;
            if ({rf_we, ld_pending} !== 2'b01) begin
                errors++;
                $display("FAIL extract_n1[%0d] got we=%b pend=%b want we=0 pend=1", i, rf_we, ld_pending);
            end
            step();
            @(negedge clk);
            tests++;
            if ({rf_we, rf_wdata} !== {1'b1, exps[i]}) begin
                errors++;
                $display("FAIL extract_n2[%0d] got we=%b data=%h want we=1 data=%h", i, rf_we, rf_wdata, exps[i]);
            end
            step();
        end
    endtask

    task automatic test_priority();
        int mcount = 0;
        int ak = 1;
        int lk = 0;
        logic exp_full;
        bit drained = 0;
        for (int c = 0; c < 8; c++) begin
            alu_valid   = 1'b1;
            alu_rd      = 5'(ak);
            alu_data    = 32'hA0000000 | 32'(ak);
            ld_valid    = 1'b1;
            ld_rd       = 5'(16 + (lk % 16));
            ld_data     = 32'h10000000 + 32'(lk) * 32'h111;
            ld_size     = 2'd2;
            ld_unsigned = 1'b0;
            ld_offset   = 2'd0;
            exp_full    = (mcount == 2);
            @(negedge clk);
            tests++;
            if ({alu_ready, ld_ready} !== {!exp_full, !exp_full}) begin
                errors++;
                $display("FAIL priority_ready[%0d] got alur=%b ldr=%b want %b", c, alu_ready, ld_ready, !exp_full);
            end
            if (!exp_full) begin
                alu_exp.push_back({5'(ak), 32'hA0000000 | 32'(ak)});
                ld_exp.push_back({5'(16 + (lk % 16)), 32'h10000000 + 32'(lk) * 32'h111});
                ak++;
                lk++;
                mcount++;
            end else begin
                mcount--;
            end
            step();
        end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        for (int c = 0; c < 10 && !drained; c++) begin
            @(negedge clk);
            if (!ld_pending) drained = 1;
            step();
        end
        tests++;
        if (!drained) begin
            errors++;
            $display("FAIL priority_drain got pending=1 after 10 cycles want 0");
        end
        step();
        step();
        tests++;
        if (alu_exp.size() + ld_exp.size() != 0) begin
            errors++;
            $display("FAIL priority_all_written got %0d outstanding want 0", alu_exp.size() + ld_exp.size());
        end
    endtask

    task automatic test_x0();
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'h12345678;
        @(negedge clk);
        tests++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_alu_ready got %b want 1", alu_ready);
        end
        step();
        alu_valid   = 1'b0;
        ld_valid    = 1'b1;
        ld_rd       = 5'd0;
        ld_data     = 32'hCAFEF00D;
        ld_size     = 2'd2;
        @(negedge clk);
        tests++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL x0_alu_we got %b want 0", rf_we);
        end
        step();
        ld_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (ld_pending !== 1'b1) begin
            errors++;
            $display("FAIL x0_ld_queued got pending=%b want 1", ld_pending);
        end
        step();
        @(negedge clk);
        tests++;
        if ({ld_pending, rf_we} !== 2'b00) begin
            errors++;
            $display("FAIL x0_ld_popped got pending=%b we=%b want 0 0", ld_pending, rf_we);
        end
        step();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) begin
            ld_valid    = 1'b1;
            ld_rd       = 5'(20 + i);
            ld_data     = 32'h5A000000 + 32'(i);
            ld_size     = 2'd2;
            ld_unsigned = 1'b1;
            ld_offset   = 2'(i);
            ld_exp.push_back({5'(20 + i), 32'h5A000000 + 32'(i)});
            @(negedge clk);
            tests++;
            if (ld_ready !== 1'b1) begin
                errors++;
                $display("FAIL wrap_ready[%0d] got %b want 1", i, ld_ready);
            end
            if (i > 0) begin
                tests++;
                if (ld_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_pending[%0d] got %b want 1", i, ld_pending);
                end
            end
            step();
        end
        ld_valid = 1'b0;
        repeat (3) step();
        tests++;
        if (ld_exp.size() != 0 || ld_pending !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain got outstanding=%0d pending=%b want 0 0", ld_exp.size(), ld_pending);
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 32'h77777777;
        ld_valid  = 1'b1;
        ld_rd     = 5'd30;
        ld_data   = 32'h33333333;
        ld_size   = 2'd2;
        alu_exp.push_back({5'd7, 32'h77777777});
        step();
        alu_rd   = 5'd8;
        alu_data = 32'h88888888;
        ld_rd    = 5'd31;
        ld_data  = 32'h44444444;
        alu_exp.push_back({5'd8, 32'h88888888});
        step();
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        @(negedge clk);
        tests++;
        if ({ld_pending, ld_ready, alu_ready} !== 3'b100) begin
            errors++;
            $display("FAIL mid_full got pend=%b ldr=%b alur=%b want 1 0 0", ld_pending, ld_ready, alu_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({rf_we, ld_pending, ld_ready} !== 3'b001) begin
            errors++;
            $display("FAIL mid_reset got we=%b pend=%b ldr=%b want 0 0 1", rf_we, ld_pending, ld_ready);
        end
        #5 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rf_we !== 1'b0) stale++;
        end
        tests++;
        if (stale != 0) begin
            errors++;
            $display("FAIL mid_stale got %0d writes want 0", stale);
        end
        tests++;
        if (alu_exp.size() + ld_exp.size() != 0) begin
            errors++;
            $display("FAIL mid_outstanding got %0d want 0", alu_exp.size() + ld_exp.size());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_data    = '0;
        ld_valid    = 1'b0;
        ld_rd       = 5'd0;
        ld_data     = '0;
        ld_size     = 2'd0;
        ld_unsigned = 1'b0;
        ld_offset   = 2'd0;
        test_reset();
        test_extract();
        test_priority();
        test_x0();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
